// File: rtl/cmd_issuer.sv
// Pushbutton front end for the stack-calculator control unit: synchronizes and
// debounces a raw button and mode switches, issuing one clean ex_n pulse per press.
module cmd_issuer #(
   parameter int DB_CYCLES = 16,
   parameter int DB_W      = 20,
   parameter int PULSE_LEN = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_n,
   input  logic [1:0] sw_mode,
   output logic       ex_n,
   output logic [1:0] mode,
   output logic       busy,
   output logic [7:0] cmd_cnt
);

   localparam int PL_W = $clog2(PULSE_LEN + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRESS_DB = 3'd1;
   localparam logic [2:0] S_SETUP    = 3'd2;
   localparam logic [2:0] S_PULSE    = 3'd3;
   localparam logic [2:0] S_HOLD     = 3'd4;
   localparam logic [2:0] S_REL_DB   = 3'd5;

   logic            btn_meta_q, btn_meta_d;
   logic            btn_s_q, btn_s_d;
   logic [1:0]      sw_meta_q, sw_meta_d;
   logic [1:0]      sw_s_q, sw_s_d;
   logic [2:0]      state_q, state_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [PL_W-1:0] pl_cnt_q, pl_cnt_d;
   logic            ex_n_q, ex_n_d;
   logic [1:0]      mode_q, mode_d;
   logic [7:0]      cmd_cnt_q, cmd_cnt_d;

   always_comb begin
      btn_meta_d = btn_n;
      btn_s_d    = btn_meta_q;
      sw_meta_d  = sw_mode;
      sw_s_d     = sw_meta_q;
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      pl_cnt_d   = pl_cnt_q;
      ex_n_d     = ex_n_q;
      mode_d     = mode_q;
      cmd_cnt_d  = cmd_cnt_q;

      case (state_q)
         S_IDLE: begin
            ex_n_d = 1'b1;
            if (!btn_s_q) begin
               state_d  = S_PRESS_DB;
               db_cnt_d = DB_W'(1);
            end
         end
         S_PRESS_DB: begin
            if (btn_s_q) begin
               state_d = S_IDLE;
            end else if (db_cnt_q == DB_W'(DB_CYCLES)) begin
               // Mode is latched here only, so it is settled a full cycle before ex_n falls.
               state_d = S_SETUP;
               mode_d  = sw_s_q;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         S_SETUP: begin
            state_d   = S_PULSE;
            pl_cnt_d  = PL_W'(1);
            ex_n_d    = 1'b0;
            cmd_cnt_d = cmd_cnt_q + 8'd1;
         end
         S_PULSE: begin
            if (pl_cnt_q == PL_W'(PULSE_LEN)) begin
               state_d = S_HOLD;
               ex_n_d  = 1'b1;
            end else begin
               pl_cnt_d = pl_cnt_q + PL_W'(1);
            end
         end
         S_HOLD: begin
            ex_n_d = 1'b1;
            if (btn_s_q) begin
               state_d  = S_REL_DB;
               db_cnt_d = DB_W'(1);
            end
         end
         S_REL_DB: begin
            if (!btn_s_q) begin
               state_d = S_HOLD;
            end else if (db_cnt_q == DB_W'(DB_CYCLES)) begin
               state_d = S_IDLE;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            ex_n_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_q <= 1'b1;
         btn_s_q    <= 1'b1;
         sw_meta_q  <= 2'b00;
         sw_s_q     <= 2'b00;
         state_q    <= S_IDLE;
         db_cnt_q   <= '0;
         pl_cnt_q   <= '0;
         ex_n_q     <= 1'b1;
         mode_q     <= 2'b00;
         cmd_cnt_q  <= 8'd0;
      end else begin
         btn_meta_q <= btn_meta_d;
         btn_s_q    <= btn_s_d;
         sw_meta_q  <= sw_meta_d;
         sw_s_q     <= sw_s_d;
         state_q    <= state_d;
         db_cnt_q   <= db_cnt_d;
         pl_cnt_q   <= pl_cnt_d;
         ex_n_q     <= ex_n_d;
         mode_q     <= mode_d;
         cmd_cnt_q  <= cmd_cnt_d;
      end
   end

   assign ex_n    = ex_n_q;
   assign mode    = mode_q;
   assign cmd_cnt = cmd_cnt_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmd_issuer.sv
// Bench for cmd_issuer: random press/bounce episodes checked every cycle against
// a timeline model of when each accepted press must produce its ex_n pulse.
module tb_cmd_issuer;

   localparam int DB        = 4;
   localparam int PULSE_LEN = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_n;
   logic [1:0] sw_mode;
   logic       ex_n;
   logic [1:0] mode;
   logic       busy;
   logic [7:0] cmd_cnt;

   cmd_issuer #(.DB_CYCLES(DB), .DB_W(8), .PULSE_LEN(PULSE_LEN)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (btn_n),
      .sw_mode (sw_mode),
      .ex_n    (ex_n),
      .mode    (mode),
      .busy    (busy),
      .cmd_cnt (cmd_cnt)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         edge_cnt = 0;
   // Expected ex_n falling edges (edge index) and the mode each must carry.
   int         fall_q[$];
   logic [1:0] mode_q[$];
   int         rd = 0;
   int         pulse_end = 0;
   int         exp_cnt = 0;
   logic [1:0] cur_mode = 2'b00;
   bit         chk_en = 1'b0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 time unit after each edge and comparing
   // all registered outputs with the timeline model.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         edge_cnt++;
         if (rd < fall_q.size()) begin
            if (edge_cnt == fall_q[rd] - 1) cur_mode = mode_q[rd];
            if (edge_cnt == fall_q[rd]) begin
               pulse_end = edge_cnt + PULSE_LEN;
               exp_cnt++;
               rd++;
            end
         end
         if (chk_en) begin
            chk("ex_n", {7'd0, ex_n}, (edge_cnt < pulse_end) ? 8'd0 : 8'd1);
            chk("mode", {6'd0, mode}, {6'd0, cur_mode});
            chk("cmd_cnt", cmd_cnt, exp_cnt[7:0]);
         end
      end
   endtask

   // A low run of more than DB cycles from idle is a press; its pulse starts
   // DB+4 edges after btn_n is driven low (2 sync edges + IDLE sample + DB + SETUP).
   task automatic episode(input bit real_press, input int n_pre, input int low_len,
                          input int n_rel, input logic [1:0] sw);
      sw_mode = sw;
      for (int p = 0; p < n_pre; p++) begin
         btn_n = 1'b0;
         tick($urandom_range(1, DB));
         btn_n = 1'b1;
         tick($urandom_range(1, 3));
      end
      if (real_press) begin
         fall_q.push_back(edge_cnt + DB + 4);
         mode_q.push_back(sw);
         btn_n = 1'b0;
         for (int i = 0; i < low_len; i++) begin
            if (i == DB + 3) sw_mode = 2'($urandom);
            tick(1);
         end
         chk("busy_hold", {7'd0, busy}, 8'd1);
         for (int r = 0; r < n_rel; r++) begin
            btn_n = 1'b1;
            tick($urandom_range(1, DB));
            btn_n = 1'b0;
            tick($urandom_range(1, 3));
            sw_mode = 2'($urandom);
         end
         btn_n = 1'b1;
         tick(DB + 2);
         chk("busy_rel_db", {7'd0, busy}, 8'd1);
         tick(1);
         chk("busy_idle", {7'd0, busy}, 8'd0);
      end else begin
         btn_n = 1'b1;
         tick(DB + 2);
         chk("busy_reject", {7'd0, busy}, 8'd0);
      end
      tick(2);
   endtask

   initial begin
      int reals;
      rst_n   = 1'b0;
      btn_n   = 1'b1;
      sw_mode = 2'b00;
      tick(3);
      rst_n = 1'b1;
      chk("rst_ex_n", {7'd0, ex_n}, 8'd1);
      chk("rst_mode", {6'd0, mode}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_cmd_cnt", cmd_cnt, 8'd0);
      chk_en = 1'b1;
      tick(3);

      // Clean press with mode 01.
      episode(1'b1, 0, DB + 10, 0, 2'b01);
      chk("first_cmd_cnt", cmd_cnt, 8'd1);

      // Short bounces never reach the control unit.
      for (int b = 0; b < 5; b++) begin
         btn_n = 1'b0;
         tick(3);
         btn_n = 1'b1;
         tick(4);
         chk("bounce_busy", {7'd0, busy}, 8'd0);
      end
      chk("bounce_cmd_cnt", cmd_cnt, 8'd1);

      // Long hold with release bounces, then mode toggles followed by a mode-11 press.
      episode(1'b1, 0, 100, 3, 2'b10);
      episode(1'b1, 2, DB + 12, 2, 2'b00);
      episode(1'b1, 0, DB + 8, 0, 2'b11);

      // Asynchronous reset in the middle of a pulse.
      sw_mode = 2'b10;
      fall_q.push_back(edge_cnt + DB + 4);
      mode_q.push_back(2'b10);
      btn_n = 1'b0;
      while (edge_cnt < fall_q[fall_q.size() - 1]) tick(1);
      rst_n = 1'b0;
      #1;
      chk("midrst_ex_n", {7'd0, ex_n}, 8'd1);
      chk("midrst_mode", {6'd0, mode}, 8'd0);
      chk("midrst_cmd_cnt", cmd_cnt, 8'd0);
      chk("midrst_busy", {7'd0, busy}, 8'd0);
      btn_n     = 1'b1;
      chk_en    = 1'b0;
      exp_cnt   = 0;
      cur_mode  = 2'b00;
      pulse_end = 0;
      tick(3);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick(20);

      // Random episodes until exactly 256 commands have issued since reset.
      reals = 0;
      while (reals < 256) begin
         bit rp;
         rp = ($urandom_range(0, 4) != 0);
         if (rp) reals++;
         episode(rp, $urandom_range(0, 3), DB + 8 + $urandom_range(0, 20),
                 $urandom_range(0, 3), 2'($urandom));
      end
      chk("wrap_cmd_cnt", cmd_cnt, 8'd0);
      chk("wrap_busy", {7'd0, busy}, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
